// File: rtl/ieee1500_wsp_controller.sv
// ieee1500_wsp_controller: sequences one IR or DR scan through an IEEE 1500
// Wrapper Serial Port per host command and returns the scanned-out bits.
module ieee1500_wsp_controller #(
    parameter int IR_WIDTH = 3,
    parameter int DR_WIDTH = 16
) (
    input  logic                wrck,
    input  logic                wrst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic                cmd_update,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                selectwir,
    output logic                capturewir,
    output logic                shiftwir,
    output logic                updatewir,
    output logic                selectwdr,
    output logic                capturewdr,
    output logic                shiftwdr,
    output logic                updatewdr,
    output logic                wsi,
    input  logic                wso
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);
    localparam logic [CNT_W-1:0] IR_LAST = CNT_W'(IR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                is_ir_q;
    logic                update_q;
    logic [DR_WIDTH-1:0] sdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;
    logic                shift_last;
    logic                is_ir_nxt;
    logic                sel_nxt;
    logic                cap_nxt;
    logic                sh_nxt;
    logic                upd_nxt;

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign rsp_valid  = (state == S_DONE);
    assign accept     = cmd_valid & cmd_ready;
    assign shift_last = (cnt_q == (is_ir_q ? IR_LAST : DR_LAST));
    // Register choice for the strobes about to be issued: the fresh command on accept.
    assign is_ir_nxt  = accept ? cmd_is_ir : is_ir_q;

    // Next-state logic and decode of the strobes that belong to the next state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:    if (cmd_valid) state_nxt = S_SELECT;
            S_SELECT:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_SHIFT;
            S_SHIFT:   if (shift_last) state_nxt = (is_ir_q | update_q) ? S_UPDATE : S_DONE;
            S_UPDATE:  state_nxt = S_DONE;
            S_DONE:    if (rsp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        sel_nxt = state_nxt inside {S_SELECT, S_CAPTURE, S_SHIFT, S_UPDATE};
        cap_nxt = (state_nxt == S_CAPTURE);
        sh_nxt  = (state_nxt == S_SHIFT);
        upd_nxt = (state_nxt == S_UPDATE);
    end

    // State register.
    always_ff @(posedge wrck) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (wrst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Command latch, shift counter and scan-in data that feeds wsi LSB first.
    always_ff @(posedge wrck) begin
        if (wrst) begin
            is_ir_q  <= 1'b0;
            update_q <= 1'b0;
            sdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                is_ir_q  <= cmd_is_ir;
                update_q <= cmd_update;
                sdata_q  <= cmd_data;
                cnt_q    <= '0;
            end
            if (state == S_SHIFT) cnt_q <= cnt_q + CNT_W'(1);
            if (state_nxt == S_SHIFT) sdata_q <= sdata_q >> 1;
        end
    end

    // WSP strobes and wsi are registered from the next state so they align with it.
    always_ff @(posedge wrck) begin
        if (wrst) begin
            selectwir  <= 1'b0;
            capturewir <= 1'b0;
            shiftwir   <= 1'b0;
            updatewir  <= 1'b0;
            selectwdr  <= 1'b0;
            capturewdr <= 1'b0;
            shiftwdr   <= 1'b0;
            updatewdr  <= 1'b0;
            wsi        <= 1'b0;
        end else begin
            selectwir  <= sel_nxt &  is_ir_nxt;
            capturewir <= cap_nxt &  is_ir_nxt;
            shiftwir   <= sh_nxt  &  is_ir_nxt;
            updatewir  <= upd_nxt &  is_ir_nxt;
            selectwdr  <= sel_nxt & ~is_ir_nxt;
            capturewdr <= cap_nxt & ~is_ir_nxt;
            shiftwdr   <= sh_nxt  & ~is_ir_nxt;
            updatewdr  <= upd_nxt & ~is_ir_nxt;
            wsi        <= sh_nxt  & sdata_q[0];
        end
    end

    // Store wso into the response bit indexed by the current shift cycle.
    always_ff @(posedge wrck) begin
        if (wrst) begin
            rsp_data <= '0;
        end else if (accept) begin
            rsp_data <= '0;
        end else if (state == S_SHIFT) begin
            for (int i = 0; i < DR_WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) rsp_data[i] <= wso;
            end
        end
    end

endmodule

// File: tb/tb_ieee1500_wsp_controller.sv
// Self-checking bench for ieee1500_wsp_controller with a small wrapper model
// (WIR, bypass, boundary register) answering on wso.
module tb_ieee1500_wsp_controller;

    localparam int IR_W = 3;
    localparam int DR_W = 16;
    localparam logic [11:0] IDLE_VEC = 12'b0000_0000_0010;

    logic        wrck       = 1'b0;
    logic        wrst       = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic        cmd_is_ir  = 1'b0;
    logic        cmd_update = 1'b0;
    logic [15:0] cmd_data   = '0;
    logic        rsp_ready  = 1'b0;
    logic        cmd_ready, rsp_valid, busy;
    logic [15:0] rsp_data;
    logic        selectwir, capturewir, shiftwir, updatewir;
    logic        selectwdr, capturewdr, shiftwdr, updatewdr;
    logic        wsi, wso;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    always #5 wrck = ~wrck;

    ieee1500_wsp_controller dut (
        .wrck(wrck), .wrst(wrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir),
        .cmd_update(cmd_update), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .selectwir(selectwir), .capturewir(capturewir), .shiftwir(shiftwir), .updatewir(updatewir),
        .selectwdr(selectwdr), .capturewdr(capturewdr), .shiftwdr(shiftwdr), .updatewdr(updatewdr),
        .wsi(wsi), .wso(wso)
    );

    // ---------------- wrapper model driving wso ----------------
    logic [2:0]  wir_sr    = 3'b000;
    logic [2:0]  wir_instr = 3'b000;
    logic        byp       = 1'b0;
    logic [15:0] bsr       = '0;
    logic [15:0] bsr_upd   = '0;
    logic [15:0] core_in   = '0;
    logic [7:0]  core_outputs;

    always @(posedge wrck) begin
        if (capturewir)    wir_sr <= 3'b101;
        else if (shiftwir) wir_sr <= {wsi, wir_sr[2:1]};
        if (updatewir)     wir_instr <= wir_sr;
        if (selectwdr) begin
            if (wir_instr == 3'b000) begin
                if (capturewdr)    byp <= 1'b0;
                else if (shiftwdr) byp <= wsi;
            end else begin
                if (capturewdr)    bsr <= core_in;
                else if (shiftwdr) bsr <= {wsi, bsr[15:1]};
                if (updatewdr)     bsr_upd <= bsr;
            end
        end
    end

    assign wso = selectwir ? wir_sr[0] : ((wir_instr == 3'b000) ? byp : bsr[0]);
    assign core_outputs = bsr_upd[7:0];

    logic [11:0] dut_vec;
    assign dut_vec = {selectwir, capturewir, shiftwir, updatewir,
                      selectwdr, capturewdr, shiftwdr, updatewdr,
                      wsi, busy, cmd_ready, rsp_valid};

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wrck);
        #1;
    endtask

    // Expected {strobes, wsi, busy, cmd_ready, rsp_valid} in cycle c after the accept edge.
    function automatic logic [11:0] exp_vec(input logic is_ir, input logic u,
                                            input logic [15:0] data, input int n, input int c);
        logic [3:0] grp;
        logic       w;
        int         d;
        d = n + 3 + (u ? 1 : 0);
        if (c >= d) return 12'b0000_0000_0101;
        grp = {1'b1, c == 2, (c >= 3 && c <= n + 2), (u && c == n + 3)};
        w   = (c >= 3 && c <= n + 2) ? data[c - 3] : 1'b0;
        return is_ir ? {grp, 4'b0000, w, 3'b100} : {4'b0000, grp, w, 3'b100};
    endfunction

    // Behavioural reference: what a scan returns and how it changes the wrapper.
    logic [2:0] ref_instr = 3'b000;
    logic [7:0] ref_core  = 8'h00;

    task automatic ref_step(input logic is_ir, input logic upd, input logic [15:0] data,
                            input logic [15:0] core, output logic [15:0] exp_rsp);
        if (is_ir) begin
            exp_rsp   = 16'h0005;
            ref_instr = data[2:0];
        end else if (ref_instr == 3'b000) begin
            exp_rsp = {data[14:0], 1'b0};
        end else begin
            exp_rsp = core;
            if (upd) ref_core = data[7:0];
        end
    endtask

    // One complete command; entered and left #1 after an edge in an IDLE cycle.
    task automatic do_cmd(input string tag, input logic is_ir, input logic upd,
                          input logic [15:0] data, input int hold, input logic garbage,
                          input logic [15:0] exp_rsp, input logic [7:0] exp_core);
        int   n;
        int   d;
        logic u;
        n = is_ir ? IR_W : DR_W;
        u = is_ir | upd;
        d = n + 3 + (u ? 1 : 0);
        cmd_valid  = 1'b1;
        cmd_is_ir  = is_ir;
        cmd_update = upd;
        cmd_data   = data;
        rsp_ready  = (hold == 0);
        for (int c = 1; c <= d; c++) begin
            step();
            cmd_valid  = garbage;
            cmd_is_ir  = 1'($urandom_range(0, 1));
            cmd_update = 1'($urandom_range(0, 1));
            cmd_data   = 16'($urandom);
            check($sformatf("%s c%0d vec", tag, c), dut_vec, exp_vec(is_ir, u, data, n, c));
        end
        check($sformatf("%s rsp_data", tag), rsp_data, exp_rsp);
        for (int h = 1; h <= hold; h++) begin
            step();
            check($sformatf("%s hold%0d vec", tag, h), dut_vec, 12'b0000_0000_0101);
            check($sformatf("%s hold%0d rsp_data", tag, h), rsp_data, exp_rsp);
            if (h == hold) rsp_ready = 1'b1;
        end
        step();
        cmd_valid = 1'b0;
        check($sformatf("%s idle vec", tag), dut_vec, IDLE_VEC);
        check($sformatf("%s core_outputs", tag), core_outputs, exp_core);
    endtask

    // Strobe exclusivity and WIR/WDR separation, every cycle.
    always @(negedge wrck) begin
        if (mon_en) begin
            logic [2:0] csu;
            logic       viol;
            csu  = {capturewir | capturewdr, shiftwir | shiftwdr, updatewir | updatewdr};
            viol = ($countones(csu) > 1) ||
                   ((selectwir | capturewir | shiftwir | updatewir) &&
                    (selectwdr | capturewdr | shiftwdr | updatewdr));
            check("exclusivity", 32'(viol), 32'h0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic        is_ir;
        logic        upd;
        logic [15:0] data;
        logic [15:0] core;
        int          hold;
        logic        garbage;
        logic [15:0] exp_rsp;
        logic [7:0]  exp_core;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [15:0] er;
        logic        r_ir, r_upd, r_garb, seen;
        logic [15:0] r_data, r_core, rst_data;
        int          r_hold;

        tbl[0] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 0, 1'b0, 16'h0005, 8'h00}; // EXTEST
        tbl[1] = '{1'b0, 1'b1, 16'hA55A, 16'h3C96, 0, 1'b0, 16'h3C96, 8'h5A};
        tbl[2] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 16'h0005, 8'h5A}; // BYPASS
        tbl[3] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 0, 1'b0, 16'h0002, 8'h5A};
        tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, 1'b1, 16'hFFFE, 8'h5A};
        tbl[5] = '{1'b1, 1'b0, 16'h7FF9, 16'h0000, 5, 1'b1, 16'h0005, 8'h5A}; // EXTEST, held rsp
        tbl[6] = '{1'b0, 1'b0, 16'h8001, 16'h1234, 2, 1'b0, 16'h1234, 8'h5A};
        tbl[7] = '{1'b0, 1'b1, 16'h0F0F, 16'hABCD, 0, 1'b1, 16'hABCD, 8'h0F};
        tbl[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 16'h0005, 8'h0F}; // BYPASS
        tbl[9] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 0, 1'b0, 16'h0000, 8'h0F};

        // reset state
        wrst = 1'b1;
        repeat (3) step();
        check("reset vec", dut_vec, IDLE_VEC);
        check("reset rsp_data", rsp_data, 16'h0000);
        wrst = 1'b0;
        step();
        check("post-reset vec", dut_vec, IDLE_VEC);
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            core_in = tbl[i].core;
            ref_step(tbl[i].is_ir, tbl[i].upd, tbl[i].data, tbl[i].core, er);
            do_cmd($sformatf("tbl%0d", i), tbl[i].is_ir, tbl[i].upd, tbl[i].data,
                   tbl[i].hold, tbl[i].garbage, tbl[i].exp_rsp, tbl[i].exp_core);
        end

        // reset during DR shift cycle 5
        rst_data   = 16'hBEEF;
        core_in    = 16'h5555;
        cmd_valid  = 1'b1;
        cmd_is_ir  = 1'b0;
        cmd_update = 1'b1;
        cmd_data   = rst_data;
        rsp_ready  = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (7) step();
        check("rst shift5 strobe", {shiftwdr, wsi}, {1'b1, rst_data[5]});
        wrst = 1'b1;
        step();
        wrst = 1'b0;
        check("rst vec", dut_vec, IDLE_VEC);
        check("rst rsp_data", rsp_data, 16'h0000);
        seen = 1'b0;
        repeat (25) begin
            step();
            if (rsp_valid | busy) seen = 1'b1;
        end
        check("rst no response", 32'(seen), 32'h0);
        check("rst core_outputs", core_outputs, ref_core);
        ref_step(1'b1, 1'b0, 16'h0001, 16'h0000, er);
        do_cmd("post-rst ir", 1'b1, 1'b0, 16'h0001, 0, 1'b0, er, ref_core);

        // random command stream against the reference model
        for (int k = 0; k < 200; k++) begin
            r_ir   = ($urandom_range(0, 9) < 4);
            r_upd  = 1'($urandom_range(0, 1));
            r_data = 16'($urandom);
            if (r_ir && $urandom_range(0, 1) == 1) r_data[2:0] = 3'b000;
            r_core = 16'($urandom);
            r_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            r_garb = 1'($urandom_range(0, 1));
            core_in = r_core;
            ref_step(r_ir, r_upd, r_data, r_core, er);
            do_cmd($sformatf("rnd%0d", k), r_ir, r_upd, r_data, r_hold, r_garb, er, ref_core);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
